reorder_buffer_mc: RTL and testbench

Parametrised multi-commit reorder buffer for the out-of-order RV32 core. It allocates one instruction per cycle from the decoder and accepts results on WB_PORTS writeback channels (RS, LSB, extra ALUs). It retires up to COMMIT_WIDTH ready head entries per cycle, in program order, to the register file. It also resolves branch mispredicts at commit, serialises stores and stops on exit instead of calling $finish.

---
 rtl/reorder_buffer_mc.sv | 235 +++++++++++++++++++++++
 tb/tb_reorder_buffer_mc.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_mc.sv
// Multi-commit reorder buffer: in-order allocation at the tail, out-of-order
// writeback on WB_PORTS channels, and in-order retirement of up to COMMIT_WIDTH
// ready entries per cycle. Branch mispredicts resolve at commit and trigger a
// registered flush. An EX entry halts retirement.
module reorder_buffer_mc #(
    parameter int ROB_SIZE_BIT = 4,
    parameter int WB_PORTS     = 2,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               rdy_in,
    input  logic                               alloc_valid,
    input  logic                               alloc_ready,
    input  logic [1:0]                         alloc_type,
    input  logic [4:0]                         alloc_rd,
    input  logic [31:0]                        alloc_value,
    input  logic [31:0]                        alloc_pc,
    input  logic [31:0]                        alloc_jump_addr,
    input  logic [WB_PORTS-1:0]                wb_valid,
    input  logic [WB_PORTS*ROB_SIZE_BIT-1:0]   wb_rob_id,
    input  logic [WB_PORTS*32-1:0]             wb_value,
    output logic                               full,
    output logic                               empty,
    output logic [ROB_SIZE_BIT:0]              count,
    output logic [ROB_SIZE_BIT-1:0]            head_id,
    output logic [ROB_SIZE_BIT-1:0]            tail_id,
    output logic                               dep_valid,
    output logic [4:0]                         dep_rd,
    output logic [ROB_SIZE_BIT-1:0]            dep_rob_id,
    output logic [COMMIT_WIDTH-1:0]            commit_valid,
    output logic [COMMIT_WIDTH*5-1:0]          commit_rd,
    output logic [COMMIT_WIDTH*32-1:0]         commit_value,
    output logic [COMMIT_WIDTH*ROB_SIZE_BIT-1:0] commit_rob_id,
    output logic                               store_commit,
    input  logic [ROB_SIZE_BIT-1:0]            query_id1,
    input  logic [ROB_SIZE_BIT-1:0]            query_id2,
    output logic                               query_ready1,
    output logic                               query_ready2,
    output logic [31:0]                        query_value1,
    output logic [31:0]                        query_value2,
    output logic                               clear,
    output logic [31:0]                        new_pc,
    output logic                               halted
);

    localparam int ROB_SIZE = 1 << ROB_SIZE_BIT;

    typedef logic [ROB_SIZE_BIT-1:0] id_t;
    typedef logic [ROB_SIZE_BIT:0]   cnt_t;
    typedef enum logic [1:0] {
        TYPE_RG = 2'd0,
        TYPE_ST = 2'd1,
        TYPE_BR = 2'd2,
        TYPE_EX = 2'd3
    } rob_type_e;

    localparam cnt_t FULL_CNT = {1'b1, {ROB_SIZE_BIT{1'b0}}};
    localparam cnt_t CNT_ONE  = {{ROB_SIZE_BIT{1'b0}}, 1'b1};

    logic        busy_q  [ROB_SIZE];
    logic        ready_q [ROB_SIZE];
    rob_type_e   type_q  [ROB_SIZE];
    logic [4:0]  rd_q    [ROB_SIZE];
    logic [31:0] value_q [ROB_SIZE];
    logic [31:0] jump_q  [ROB_SIZE];

    id_t         head_q, tail_q, head_d, tail_d;
    cnt_t        count_q, count_d;
    logic        clear_q, halted_q;
    logic [31:0] new_pc_q;

    logic        alloc_fire;
    cnt_t        retire_cnt;
    logic        scan_stop, halt_set, mispredict;
    logic [31:0] redirect_pc;
    id_t         slot_id;
    id_t         q_id    [2];
    logic        q_ready [2];
    logic [31:0] q_value [2];

    // The PC travels with the instruction but nothing at retire needs it.
    logic unused_pc;
    assign unused_pc = ^alloc_pc;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_id    = head_q;
    assign tail_id    = tail_q;
    assign clear      = clear_q;
    assign new_pc     = new_pc_q;
    assign halted     = halted_q;

    // Allocation is suppressed while paused or flushing, so the rename
    // update never names an entry that is about to be discarded.
    assign alloc_fire = rdy_in && !clear_q && alloc_valid && !full;
    assign dep_valid  = alloc_fire && (alloc_type == TYPE_RG);
    assign dep_rd     = alloc_rd;
    assign dep_rob_id = tail_q;

    // Commit scan from head; ST/BR/EX close the retire group after themselves.
    always_comb begin
        retire_cnt    = '0;
        commit_valid  = '0;
        commit_rd     = '0;
        commit_value  = '0;
        commit_rob_id = '0;
        store_commit  = 1'b0;
        halt_set      = 1'b0;
        mispredict    = 1'b0;
        redirect_pc   = '0;
        slot_id       = '0;
        scan_stop     = halted_q || clear_q || !rdy_in;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            slot_id = head_q + id_t'(k);
            commit_rob_id[k*ROB_SIZE_BIT +: ROB_SIZE_BIT] = slot_id;
            commit_rd[k*5 +: 5]     = rd_q[slot_id];
            commit_value[k*32 +: 32] = value_q[slot_id];
            if (!scan_stop) begin
                if (busy_q[slot_id] && ready_q[slot_id]) begin
                    retire_cnt = retire_cnt + CNT_ONE;
                    case (type_q[slot_id])
                        TYPE_RG: commit_valid[k] = 1'b1;
                        TYPE_ST: begin
                            store_commit = 1'b1;
                            scan_stop    = 1'b1;
                        end
                        TYPE_BR: begin
                            scan_stop = 1'b1;
                            if (value_q[slot_id][0] ^ jump_q[slot_id][0]) begin
                                mispredict  = 1'b1;
                                redirect_pc = {jump_q[slot_id][31:1], 1'b0};
                            end
                        end
                        TYPE_EX: begin
                            halt_set  = 1'b1;
                            scan_stop = 1'b1;
                        end
                    endcase
                end else begin
                    scan_stop = 1'b1;
                end
            end
        end
    end

    // Next-state pointers and occupancy.
    always_comb begin
        head_d  = head_q + retire_cnt[ROB_SIZE_BIT-1:0];
        tail_d  = tail_q + id_t'(alloc_fire);
        count_d = count_q + cnt_t'(alloc_fire) - retire_cnt;
    end

    // Operand lookup: stored value first, else highest-index in-flight writeback.
    always_comb begin
        q_id[0] = query_id1;
        q_id[1] = query_id2;
        for (int unsigned q = 0; q < 2; q++) begin
            q_ready[q] = busy_q[q_id[q]] && ready_q[q_id[q]];
            q_value[q] = q_ready[q] ? value_q[q_id[q]] : '0;
            if (!q_ready[q]) begin
                for (int unsigned w = 0; w < WB_PORTS; w++) begin
                    if (wb_valid[w] && (wb_rob_id[w*ROB_SIZE_BIT +: ROB_SIZE_BIT] == q_id[q])) begin
                        q_ready[q] = 1'b1;
                        q_value[q] = wb_value[w*32 +: 32];
                    end
                end
            end
        end
        query_ready1 = q_ready[0];
        query_value1 = q_value[0];
        query_ready2 = q_ready[1];
        query_value2 = q_value[1];
    end

    // Entry array and control state; a registered clear flushes on the following edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            clear_q  <= 1'b0;
            new_pc_q <= '0;
            halted_q <= 1'b0;
        end else if (rdy_in) begin
            if (clear_q) begin
                for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                    busy_q[i]  <= 1'b0;
                    ready_q[i] <= 1'b0;
                end
                head_q   <= '0;
                tail_q   <= '0;
                count_q  <= '0;
                clear_q  <= 1'b0;
                new_pc_q <= '0;
            end else begin
                // Ascending channel order lets the higher index win on a shared id.
                for (int unsigned w = 0; w < WB_PORTS; w++) begin
                    if (wb_valid[w] && busy_q[wb_rob_id[w*ROB_SIZE_BIT +: ROB_SIZE_BIT]]) begin
                        ready_q[wb_rob_id[w*ROB_SIZE_BIT +: ROB_SIZE_BIT]] <= 1'b1;
                        value_q[wb_rob_id[w*ROB_SIZE_BIT +: ROB_SIZE_BIT]] <= wb_value[w*32 +: 32];
                    end
                end
                if (alloc_fire) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= alloc_ready;
                    type_q[tail_q]  <= rob_type_e'(alloc_type);
                    rd_q[tail_q]    <= alloc_rd;
                    value_q[tail_q] <= alloc_value;
                    jump_q[tail_q]  <= alloc_jump_addr;
                end
                for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
                    if (cnt_t'(k) < retire_cnt) begin
                        busy_q[head_q + id_t'(k)]  <= 1'b0;
                        ready_q[head_q + id_t'(k)] <= 1'b0;
                    end
                end
                head_q   <= head_d;
                tail_q   <= tail_d;
                count_q  <= count_d;
                clear_q  <= mispredict;
                new_pc_q <= redirect_pc;
                if (halt_set) begin
                    halted_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed bench for reorder_buffer_mc: table-driven writeback/commit vectors
// plus hand-written sequences for flush, store, halt and pause behaviour.
module tb_reorder_buffer_mc;

    localparam int RB = 4;
    localparam int WB = 2;
    localparam int CW = 2;

    logic            clk_in = 1'b0;
    logic            rst_in, rdy_in;
    logic            alloc_valid, alloc_ready;
    logic [1:0]      alloc_type;
    logic [4:0]      alloc_rd;
    logic [31:0]     alloc_value, alloc_pc, alloc_jump_addr;
    logic [WB-1:0]   wb_valid;
    logic [WB*RB-1:0] wb_rob_id;
    logic [WB*32-1:0] wb_value;
    logic            full, empty;
    logic [RB:0]     count;
    logic [RB-1:0]   head_id, tail_id;
    logic            dep_valid;
    logic [4:0]      dep_rd;
    logic [RB-1:0]   dep_rob_id;
    logic [CW-1:0]   commit_valid;
    logic [CW*5-1:0] commit_rd;
    logic [CW*32-1:0] commit_value;
    logic [CW*RB-1:0] commit_rob_id;
    logic            store_commit;
    logic [RB-1:0]   query_id1, query_id2;
    logic            query_ready1, query_ready2;
    logic [31:0]     query_value1, query_value2;
    logic            clear;
    logic [31:0]     new_pc;
    logic            halted;

    int errors = 0;
    int checks = 0;

    reorder_buffer_mc #(
        .ROB_SIZE_BIT(RB),
        .WB_PORTS(WB),
        .COMMIT_WIDTH(CW)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_type(alloc_type),
        .alloc_rd(alloc_rd), .alloc_value(alloc_value), .alloc_pc(alloc_pc),
        .alloc_jump_addr(alloc_jump_addr),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .full(full), .empty(empty), .count(count), .head_id(head_id), .tail_id(tail_id),
        .dep_valid(dep_valid), .dep_rd(dep_rd), .dep_rob_id(dep_rob_id),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_rob_id(commit_rob_id), .store_commit(store_commit),
        .query_id1(query_id1), .query_id2(query_id2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_value1(query_value1), .query_value2(query_value2),
        .clear(clear), .new_pc(new_pc), .halted(halted)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  wv;
        logic [3:0]  id0, id1;
        logic [31:0] v0, v1;
        logic [3:0]  qid;
        logic [1:0]  cv;
        logic [4:0]  rd0, rd1;
        logic [31:0] cval0, cval1;
        logic        qr;
        logic [31:0] qv;
        logic [4:0]  cnt;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_ready = 1'b0; alloc_type = 2'd0; alloc_rd = '0;
        alloc_value = '0; alloc_pc = '0; alloc_jump_addr = '0;
        wb_valid = '0; wb_rob_id = '0; wb_value = '0;
        query_id1 = '0; query_id2 = '0;
    endtask

    task automatic alloc_set(input logic rdy, input logic [1:0] t, input logic [4:0] rd,
                             input logic [31:0] val, input logic [31:0] jmp);
        alloc_valid = 1'b1; alloc_ready = rdy; alloc_type = t; alloc_rd = rd;
        alloc_value = val; alloc_jump_addr = jmp; alloc_pc = 32'h100;
    endtask

    task automatic do_reset();
        idle();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    initial begin
        // rd of entry i is i+1; ids 0..15 are allocated not-ready before the table runs
        vt[0] = '{2'b11, 4'd0, 4'd1, 32'h11, 32'h22, 4'd1, 2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  1'b1, 32'h22, 5'd16};
        vt[1] = '{2'b10, 4'd0, 4'd2, 32'h0,  32'h33, 4'd2, 2'b11, 5'd1, 5'd2, 32'h11, 32'h22, 1'b1, 32'h33, 5'd14};
        vt[2] = '{2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  4'd5, 2'b01, 5'd3, 5'd0, 32'h33, 32'h0,  1'b0, 32'h0,  5'd13};
        vt[3] = '{2'b11, 4'd5, 4'd5, 32'hAA, 32'hBB, 4'd5, 2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  1'b1, 32'hBB, 5'd13};
        vt[4] = '{2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  4'd5, 2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  1'b1, 32'hBB, 5'd13};
        vt[5] = '{2'b11, 4'd3, 4'd4, 32'h44, 32'h55, 4'd3, 2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  1'b1, 32'h44, 5'd13};
        vt[6] = '{2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  4'd4, 2'b11, 5'd4, 5'd5, 32'h44, 32'h55, 1'b1, 32'h55, 5'd11};
        vt[7] = '{2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  4'd6, 2'b01, 5'd6, 5'd0, 32'hBB, 32'h0,  1'b0, 32'h0,  5'd10};
        vt[8] = '{2'b01, 4'd0, 4'd0, 32'h99, 32'h0,  4'd7, 2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  1'b0, 32'h0,  5'd10};
        vt[9] = '{2'b00, 4'd0, 4'd0, 32'h0,  32'h0,  4'd0, 2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  1'b0, 32'h0,  5'd10};

        // ---- reset state
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_head", 32'(head_id), 32'd0);
        chk("rst_tail", 32'(tail_id), 32'd0);
        chk("rst_clear", 32'(clear), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_new_pc", new_pc, 32'd0);

        // ---- fill to capacity
        for (int i = 0; i < 16; i++) begin
            alloc_set(1'b0, 2'd0, 5'(i + 1), 32'h0, 32'h0);
            #1;
            chk("fill_dep_valid", 32'(dep_valid), 32'd1);
            chk("fill_dep_id", 32'(dep_rob_id), 32'(i));
            step();
        end
        idle();
        #1;
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd16);
        alloc_set(1'b0, 2'd0, 5'd20, 32'h0, 32'h0);
        #1;
        chk("full_dep_blocked", 32'(dep_valid), 32'd0);
        step();
        idle();
        chk("full_tail_stays", 32'(tail_id), 32'd0);
        chk("full_count_stays", 32'(count), 32'd16);

        // ---- table-driven writeback / commit / query
        for (int i = 0; i < 10; i++) begin
            idle();
            wb_valid  = vt[i].wv;
            wb_rob_id = {vt[i].id1, vt[i].id0};
            wb_value  = {vt[i].v1, vt[i].v0};
            query_id1 = vt[i].qid;
            query_id2 = vt[i].qid;
            #1;
            chk($sformatf("v%0d_commit_valid", i), 32'(commit_valid), 32'(vt[i].cv));
            if (vt[i].cv[0]) begin
                chk($sformatf("v%0d_rd0", i), 32'(commit_rd[4:0]), 32'(vt[i].rd0));
                chk($sformatf("v%0d_val0", i), commit_value[31:0], vt[i].cval0);
            end
            if (vt[i].cv[1]) begin
                chk($sformatf("v%0d_rd1", i), 32'(commit_rd[9:5]), 32'(vt[i].rd1));
                chk($sformatf("v%0d_val1", i), commit_value[63:32], vt[i].cval1);
            end
            chk($sformatf("v%0d_qready1", i), 32'(query_ready1), 32'(vt[i].qr));
            chk($sformatf("v%0d_qvalue1", i), query_value1, vt[i].qv);
            chk($sformatf("v%0d_qvalue2", i), query_value2, vt[i].qv);
            step();
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].cnt));
        end

        // ---- mispredicted branch at head with a ready RG behind it
        do_reset();
        alloc_set(1'b0, 2'd2, 5'd0, 32'h0, 32'h0000_1001);
        step();
        alloc_set(1'b1, 2'd0, 5'd7, 32'h77, 32'h0);
        step();
        idle();
        wb_valid = 2'b01; wb_rob_id = '0; wb_value = '0;
        #1;
        chk("br_wb_not_yet", 32'(commit_valid), 32'd0);
        chk("br_wb_count", 32'(count), 32'd2);
        step();
        idle();
        #1;
        chk("br_commit_valid", 32'(commit_valid), 32'd0);
        chk("br_store_commit", 32'(store_commit), 32'd0);
        step();
        chk("br_clear", 32'(clear), 32'd1);
        chk("br_new_pc", new_pc, 32'h0000_1000);
        chk("br_only_branch", 32'(count), 32'd1);
        chk("br_no_commit_on_clear", 32'(commit_valid), 32'd0);
        step();
        chk("br_clear_done", 32'(clear), 32'd0);
        chk("br_flush_count", 32'(count), 32'd0);
        chk("br_flush_empty", 32'(empty), 32'd1);
        chk("br_flush_head", 32'(head_id), 32'd0);
        chk("br_flush_tail", 32'(tail_id), 32'd0);

        // ---- store serialises the retire group
        do_reset();
        alloc_set(1'b0, 2'd1, 5'd0, 32'h0, 32'h0);
        step();
        alloc_set(1'b1, 2'd0, 5'd9, 32'h99, 32'h0);
        step();
        idle();
        wb_valid = 2'b01; wb_rob_id = '0; wb_value = 64'h5;
        step();
        idle();
        #1;
        chk("st_store_commit", 32'(store_commit), 32'd1);
        chk("st_commit_valid", 32'(commit_valid), 32'd0);
        step();
        chk("st_count_after", 32'(count), 32'd1);
        chk("st_rg_store_commit", 32'(store_commit), 32'd0);
        chk("st_rg_commit_valid", 32'(commit_valid), 32'd1);
        chk("st_rg_rd", 32'(commit_rd[4:0]), 32'd9);
        chk("st_rg_value", commit_value[31:0], 32'h99);
        chk("st_rg_rob_id", 32'(commit_rob_id[3:0]), 32'd1);
        step();
        chk("st_empty", 32'(empty), 32'd1);

        // ---- pause freezes state, then EX halts retirement
        do_reset();
        alloc_set(1'b1, 2'd0, 5'd1, 32'h10, 32'h0);
        step();
        rdy_in = 1'b0;
        alloc_set(1'b1, 2'd0, 5'd2, 32'h20, 32'h0);
        for (int r = 0; r < 3; r++) begin
            #1;
            chk("pause_commit_valid", 32'(commit_valid), 32'd0);
            chk("pause_dep_valid", 32'(dep_valid), 32'd0);
            chk("pause_store_commit", 32'(store_commit), 32'd0);
            step();
            chk("pause_count", 32'(count), 32'd1);
            chk("pause_head", 32'(head_id), 32'd0);
            chk("pause_tail", 32'(tail_id), 32'd1);
        end
        rdy_in = 1'b1;
        alloc_set(1'b0, 2'd3, 5'd0, 32'h0, 32'h0);
        #1;
        chk("resume_commit_valid", 32'(commit_valid), 32'd1);
        chk("resume_rd", 32'(commit_rd[4:0]), 32'd1);
        chk("resume_value", commit_value[31:0], 32'h10);
        step();
        chk("resume_count", 32'(count), 32'd1);
        chk("resume_head", 32'(head_id), 32'd1);
        chk("resume_tail", 32'(tail_id), 32'd2);
        alloc_set(1'b1, 2'd0, 5'd3, 32'h30, 32'h0);
        wb_valid = 2'b01; wb_rob_id = {4'd0, 4'd1}; wb_value = '0;
        #1;
        chk("ex_wb_not_yet", 32'(commit_valid), 32'd0);
        step();
        idle();
        #1;
        chk("ex_count_before", 32'(count), 32'd2);
        chk("ex_commit_valid", 32'(commit_valid), 32'd0);
        chk("ex_not_halted_yet", 32'(halted), 32'd0);
        step();
        chk("ex_halted", 32'(halted), 32'd1);
        chk("ex_count", 32'(count), 32'd1);
        chk("ex_head", 32'(head_id), 32'd2);
        chk("ex_no_more_commit", 32'(commit_valid), 32'd0);
        step();
        chk("ex_count_frozen", 32'(count), 32'd1);
        chk("ex_halted_sticky", 32'(halted), 32'd1);
        do_reset();
        chk("ex_rst_halted", 32'(halted), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
